// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package instruction_fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IF_FETCH   = 2'd0,
    IF_HOLD    = 2'd1,
    IF_DISCARD = 2'd2
  } if_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_skid_buffer.sv
// One-entry holding register for an instruction fetched while decode was stalled.
module fetch_skid_buffer
  import instruction_fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        full
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr <= NOP_INSTR;
      pc    <= '0;
      full  <= 1'b0;
    end else if (load) begin
      instr <= instr_in;
      pc    <= pc_in;
      full  <= 1'b1;
    end else if (clear) begin
      full  <= 1'b0;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, issues busywait-handshaked reads, and drives the IF/ID register.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [31:0] IMEM_ADDR,
  output logic        IMEM_READ,
  input  logic [31:0] IMEM_INSTR,
  input  logic        IMEM_BUSYWAIT,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  input  logic        STALL,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_INSTR,
  output logic        IF_VALID,
  output logic        IF_BUSY
);

  if_state_e   state, state_n;
  logic [31:0] pc, pc_n, pc_plus4;
  logic [31:0] pend_target, pend_target_n;
  logic [31:0] if_pc_n, if_instr_n;
  logic        if_valid_n;
  logic [31:0] target;
  logic        read_req, complete;
  logic        skid_load, skid_clear, skid_full;
  logic [31:0] skid_instr, skid_pc;

  assign target   = word_align(BRANCH_TARGET);
  assign pc_plus4 = pc + 32'd4;
  assign read_req = (state != IF_HOLD);
  assign complete = read_req && !IMEM_BUSYWAIT;

  // PC is left untouched while DISCARD waits, so it still holds the abandoned address.
  assign IMEM_ADDR = pc;
  assign IMEM_READ = read_req && !RESET;
  assign IF_BUSY   = IMEM_READ && IMEM_BUSYWAIT;

  fetch_skid_buffer u_skid (
    .clk      (CLK),
    .rst      (RESET),
    .load     (skid_load),
    .clear    (skid_clear),
    .instr_in (IMEM_INSTR),
    .pc_in    (pc),
    .instr    (skid_instr),
    .pc       (skid_pc),
    .full     (skid_full)
  );

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    pend_target_n = pend_target;
    if_pc_n       = IF_PC;
    if_instr_n    = IF_INSTR;
    if_valid_n    = IF_VALID;
    skid_load     = 1'b0;
    skid_clear    = 1'b0;

    unique case (state)
      IF_FETCH: begin
        if (BRANCH_TAKEN) begin
          if_valid_n = 1'b0;
          if (IMEM_BUSYWAIT) begin
            pend_target_n = target;
            state_n       = IF_DISCARD;
          end else begin
            pc_n = target;
          end
        end else if (complete) begin
          pc_n = pc_plus4;
          if (STALL) begin
            skid_load = 1'b1;
            state_n   = IF_HOLD;
          end else begin
            if_instr_n = IMEM_INSTR;
            if_pc_n    = pc;
            if_valid_n = 1'b1;
          end
        end else if (!STALL) begin
          if_valid_n = 1'b0;
        end
      end

      IF_HOLD: begin
        if (BRANCH_TAKEN) begin
          pc_n       = target;
          skid_clear = 1'b1;
          if_valid_n = 1'b0;
          state_n    = IF_FETCH;
        end else if (!STALL) begin
          if_instr_n = skid_instr;
          if_pc_n    = skid_pc;
          if_valid_n = skid_full;
          skid_clear = 1'b1;
          state_n    = IF_FETCH;
        end
      end

      IF_DISCARD: begin
        if_valid_n = 1'b0;
        if (BRANCH_TAKEN) pend_target_n = target;
        // A redirect landing on the completion edge wins over the stored target.
        if (complete) begin
          pc_n    = BRANCH_TAKEN ? target : pend_target;
          state_n = IF_FETCH;
        end
      end

      default: begin
        state_n    = IF_FETCH;
        if_valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IF_FETCH;
      pc          <= RESET_VECTOR;
      pend_target <= '0;
      IF_PC       <= '0;
      IF_INSTR    <= NOP_INSTR;
      IF_VALID    <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      pend_target <= pend_target_n;
      IF_PC       <= if_pc_n;
      IF_INSTR    <= if_instr_n;
      IF_VALID    <= if_valid_n;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a combinational instruction memory model.
module tb_instruction_fetch_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_READ;
  logic [31:0] IMEM_INSTR;
  logic        IMEM_BUSYWAIT;
  logic        BRANCH_TAKEN;
  logic [31:0] BRANCH_TARGET;
  logic        STALL;
  logic [31:0] IF_PC;
  logic [31:0] IF_INSTR;
  logic        IF_VALID;
  logic        IF_BUSY;

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign IMEM_INSTR = mem(IMEM_ADDR);

  always #5 CLK = ~CLK;

  instruction_fetch_unit #(.RESET_VECTOR(32'h0000_0100)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .IMEM_ADDR     (IMEM_ADDR),
    .IMEM_READ     (IMEM_READ),
    .IMEM_INSTR    (IMEM_INSTR),
    .IMEM_BUSYWAIT (IMEM_BUSYWAIT),
    .BRANCH_TAKEN  (BRANCH_TAKEN),
    .BRANCH_TARGET (BRANCH_TARGET),
    .STALL         (STALL),
    .IF_PC         (IF_PC),
    .IF_INSTR      (IF_INSTR),
    .IF_VALID      (IF_VALID),
    .IF_BUSY       (IF_BUSY)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] pc, input logic valid);
    chk({tag, ".if_valid"}, {31'd0, IF_VALID}, {31'd0, valid});
    if (valid) begin
      chk({tag, ".if_pc"}, IF_PC, pc);
      chk({tag, ".if_instr"}, IF_INSTR, mem(pc));
    end
  endtask

  initial begin
    RESET = 1'b1; IMEM_BUSYWAIT = 1'b0; BRANCH_TAKEN = 1'b0;
    BRANCH_TARGET = '0; STALL = 1'b0;
    #2;
    chk("rst.imem_read", {31'd0, IMEM_READ}, 32'd0);
    chk("rst.if_valid", {31'd0, IF_VALID}, 32'd0);
    chk("rst.if_pc", IF_PC, 32'd0);
    chk("rst.if_instr", IF_INSTR, NOP);
    chk("rst.imem_addr", IMEM_ADDR, 32'h100);
    tick();
    RESET = 1'b0;
    #1;
    chk("seq.addr0", IMEM_ADDR, 32'h100);
    chk("seq.read0", {31'd0, IMEM_READ}, 32'd1);

    // edge1: 0x100 delivered; start a 3-cycle busywait at 0x104
    tick();
    chk_out("seq.e1", 32'h100, 1'b1);
    IMEM_BUSYWAIT = 1'b1;
    #1;
    chk("bw.addr", IMEM_ADDR, 32'h104);
    chk("bw.busy", {31'd0, IF_BUSY}, 32'd1);
    tick();
    chk_out("bw.bubble1", 32'h0, 1'b0);
    chk("bw.addr_hold1", IMEM_ADDR, 32'h104);
    chk("bw.busy2", {31'd0, IF_BUSY}, 32'd1);
    tick();
    chk_out("bw.bubble2", 32'h0, 1'b0);
    tick();
    chk_out("bw.bubble3", 32'h0, 1'b0);
    chk("bw.addr_hold3", IMEM_ADDR, 32'h104);
    IMEM_BUSYWAIT = 1'b0;
    #1;
    chk("bw.busy_off", {31'd0, IF_BUSY}, 32'd0);
    tick();
    chk_out("bw.done", 32'h104, 1'b1);
    chk("stall.addr", IMEM_ADDR, 32'h108);

    // stall two cycles while 0x108 completes
    STALL = 1'b1;
    tick();
    chk_out("stall.hold1", 32'h104, 1'b1);
    chk("stall.read", {31'd0, IMEM_READ}, 32'd0);
    chk("stall.addr_next", IMEM_ADDR, 32'h10C);
    tick();
    chk_out("stall.hold2", 32'h104, 1'b1);
    chk("stall.read2", {31'd0, IMEM_READ}, 32'd0);
    STALL = 1'b0;
    tick();
    chk_out("stall.skid", 32'h108, 1'b1);
    chk("stall.read_resume", {31'd0, IMEM_READ}, 32'd1);
    chk("stall.addr_resume", IMEM_ADDR, 32'h10C);
    tick();
    chk_out("stall.next", 32'h10C, 1'b1);
    chk("disc.addr", IMEM_ADDR, 32'h110);

    // redirect during busywait at 0x110, then re-redirect in DISCARD
    IMEM_BUSYWAIT = 1'b1; BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h300;
    tick();
    chk("disc.valid1", {31'd0, IF_VALID}, 32'd0);
    chk("disc.addr_hold", IMEM_ADDR, 32'h110);
    chk("disc.read", {31'd0, IMEM_READ}, 32'd1);
    BRANCH_TARGET = 32'h400;
    tick();
    chk("disc.valid2", {31'd0, IF_VALID}, 32'd0);
    chk("disc.addr_hold2", IMEM_ADDR, 32'h110);
    BRANCH_TAKEN = 1'b0; IMEM_BUSYWAIT = 1'b0;
    tick();
    chk("disc.valid3", {31'd0, IF_VALID}, 32'd0);
    chk("disc.no_leak", IF_INSTR, mem(32'h10C));
    chk("disc.target", IMEM_ADDR, 32'h400);
    tick();
    chk_out("disc.first", 32'h400, 1'b1);

    // zero-wait redirect to 0x200
    BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h200;
    tick();
    BRANCH_TAKEN = 1'b0;
    chk("br.valid", {31'd0, IF_VALID}, 32'd0);
    chk("br.addr", IMEM_ADDR, 32'h200);
    tick();
    chk_out("br.first", 32'h200, 1'b1);

    // unaligned target is forced to word alignment
    BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h203;
    tick();
    BRANCH_TAKEN = 1'b0;
    chk("br3.valid", {31'd0, IF_VALID}, 32'd0);
    chk("br3.addr", IMEM_ADDR, 32'h200);
    tick();
    chk_out("br3.first", 32'h200, 1'b1);

    // PC wrap at the top of the address space
    BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'hFFFF_FFFC;
    tick();
    BRANCH_TAKEN = 1'b0;
    chk("wrap.addr", IMEM_ADDR, 32'hFFFF_FFFC);
    tick();
    chk_out("wrap.top", 32'hFFFF_FFFC, 1'b1);
    chk("wrap.addr0", IMEM_ADDR, 32'h0);
    tick();
    chk_out("wrap.zero", 32'h0, 1'b1);

    // asynchronous reset during a busywait
    IMEM_BUSYWAIT = 1'b1;
    #2;
    RESET = 1'b1;
    #1;
    chk("arst.read", {31'd0, IMEM_READ}, 32'd0);
    chk("arst.busy", {31'd0, IF_BUSY}, 32'd0);
    chk("arst.valid", {31'd0, IF_VALID}, 32'd0);
    chk("arst.if_pc", IF_PC, 32'd0);
    chk("arst.if_instr", IF_INSTR, NOP);
    chk("arst.addr", IMEM_ADDR, 32'h100);
    IMEM_BUSYWAIT = 1'b0;
    tick();
    RESET = 1'b0;
    tick();
    chk_out("arst.restart", 32'h100, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Instruction fetch stage with integrated IF/ID boundary register for the RV32IM pipeline. It owns the PC and issues word reads to the instruction memory/cache over a busywait handshake. It absorbs stalls with a one-entry skid buffer and applies EX-stage branch/jump redirects. Its registered outputs feed decode, where `IF_INSTR[31:7]` drives the immediate generator and `IF_INSTR` drives the control unit and register file.

## Interface
- `RESET_VECTOR`, default 32'h0000_0000: PC value loaded on reset.
- `CLK` in 1: rising-edge clock.
- `RESET` in 1: asynchronous, active-high reset.
- `IMEM_ADDR` out 32: fetch address, word aligned.
- `IMEM_READ` out 1: read request.
- `IMEM_INSTR` in 32: read data, valid when `IMEM_READ`=1 and `IMEM_BUSYWAIT`=0.
- `IMEM_BUSYWAIT` in 1: memory not ready; may be asserted combinationally in the request cycle.
- `BRANCH_TAKEN` in 1: one-cycle redirect pulse from EX.
- `BRANCH_TARGET` in 32: redirect address; bits [1:0] are ignored and forced to 0.
- `STALL` in 1: decode cannot accept; from the hazard unit.
- `IF_PC` out 32: PC of `IF_INSTR`.
- `IF_INSTR` out 32: instruction to decode.
- `IF_VALID` out 1: `IF_INSTR` is a real instruction (0 = bubble).
- `IF_BUSY` out 1: high in any cycle where a fetch is outstanding with `IMEM_BUSYWAIT`=1. Used by the hazard unit to freeze later stages.

## Operation
- Registers: `PC`, `IF_PC`, `IF_INSTR`, `IF_VALID`, skid buffer (`SKID_INSTR`, `SKID_PC`), pending target `PEND_TARGET`, and the state.
- Reset values:
  - `PC`=`RESET_VECTOR`, `IF_PC`=0, `IF_INSTR`=32'h0000_0013 (NOP), `IF_VALID`=0.
  - Skid buffer empty; state FETCH.
  - `IMEM_READ`=0 while `RESET` is high.
- `IMEM_ADDR`=`PC` in FETCH and HOLD, and the held old PC in DISCARD. `IMEM_READ`=1 in FETCH and DISCARD, 0 in HOLD.
- A fetch completes at an edge where `IMEM_READ`=1 and `IMEM_BUSYWAIT`=0.
- State FETCH:
  - Complete, `STALL`=0: `IF_INSTR`<=`IMEM_INSTR`, `IF_PC`<=`PC`, `IF_VALID`<=1, `PC`<=`PC`+4.
  - Complete, `STALL`=1: skid<=(`IMEM_INSTR`, `PC`), `PC`<=`PC`+4, go to HOLD. Outputs hold.
  - Not complete, `STALL`=0: `IF_VALID`<=0 (bubble); `PC` unchanged.
  - Not complete, `STALL`=1: outputs hold.
- State HOLD:
  - `STALL`=0: outputs<=skid with `IF_VALID`<=1, skid empties, go to FETCH.
  - `STALL`=1: everything holds.
- State DISCARD: a fetch to the old address is still in flight. Address is held until completion.
  - On completion, the data is dropped, `PC`<=`PEND_TARGET`, go to FETCH.
  - `IF_VALID`<=0 every edge in DISCARD.
- Redirect (`BRANCH_TAKEN`=1) has priority over `STALL` and over completion:
  - FETCH with `IMEM_BUSYWAIT`=0, or HOLD: `PC`<=target, skid emptied, `IF_VALID`<=0, go to FETCH.
  - FETCH with `IMEM_BUSYWAIT`=1: `PEND_TARGET`<=target, `IF_VALID`<=0, go to DISCARD.
  - In DISCARD: `PEND_TARGET` is overwritten (latest redirect wins).
- Arithmetic: PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- `RESET` asserted mid-fetch or mid-DISCARD aborts immediately. The outstanding memory transaction is abandoned, since `IMEM_READ` drops.

## Timing
- Zero-wait memory: sustained throughput of one instruction per cycle.
- Address presented in cycle k appears on `IF_INSTR` in cycle k+1.
- Each busywait cycle adds one bubble cycle (`IF_VALID`=0).
- Redirect penalty, no busywait: the cycle after the `BRANCH_TAKEN` edge has `IF_VALID`=0, and `IMEM_ADDR`=target in that cycle.
- Leaving HOLD delivers the skid instruction at the first edge with `STALL`=0. The next fetch is issued in the same cycle the skid output becomes visible.
- All outputs are registered except `IMEM_ADDR`, `IMEM_READ` and `IF_BUSY`. These are decoded from state/`PC`, plus `IMEM_BUSYWAIT` for `IF_BUSY`.

## Structure
- Add to `encodings.v`:
  - `NOP_INSTR` (32'h0000_0013).
  - State codes `IF_FETCH`, `IF_HOLD`, `IF_DISCARD` (2-bit).
- Sub-module `fetch_skid_buffer`: one-entry instr/pc holding register with load, clear and full flag.
- PC next-value mux and +4 adder stay in the top level.

## Test plan
- Reset with `RESET_VECTOR`=32'h100, zero-wait memory, `STALL`=0 → `IMEM_ADDR` 0x100, 0x104, 0x108 on consecutive cycles; `IF_PC` follows one cycle later with `IF_VALID`=1.
- `IMEM_BUSYWAIT` high for 3 cycles at 0x104 → `IMEM_ADDR` held at 0x104, `IF_BUSY`=1 for 3 cycles, 3 bubbles, then `IF_PC`=0x104 valid.
- `STALL` high for 2 cycles while the 0x108 fetch completes → HOLD entered; `IF_PC`/`IF_INSTR` unchanged; `IMEM_READ`=0. On release, `IF_PC`=0x108, then 0x10C follows with no loss or duplication.
- `BRANCH_TAKEN` with target 0x200 (also with target 0x203) in a zero-wait cycle → next cycle `IF_VALID`=0 and `IMEM_ADDR`=0x200, then `IF_PC`=0x200 valid.
- `BRANCH_TAKEN` (target 0x300) during a 2-cycle busywait at 0x110 → DISCARD; 0x110 data never appears on `IF_INSTR`; next fetch address 0x300. A second redirect to 0x400 while in DISCARD → 0x400 used.
- `RESET` pulsed during a busywait, and PC at 32'hFFFF_FFFC → reset returns all outputs to reset values asynchronously; wrap fetches address 0x0000_0000.
